alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle integer ALU for the execute stage, successor to the single-cycle combinational ALU. Adds a valid/ready handshake on both sides, width parametrisation, RV32I compare ops (SLT/SLTU), an iterative shifter trading latency for area, and an optional iterative multiplier. Sits between decode/register-read and writeback; the pipeline stalls on `in_ready` low.

## Interface
- `WIDTH`, 32, operand/result width; ≥ 8, power of two.
- `SHIFT_STEP`, 1, bits shifted per cycle in the iterative shifter; power of two, 1..`WIDTH`.
- `clock` input 1 — single clock, all state on rising edge.
- `reset` input 1 — asynchronous, active-high.
- `in_valid` input 1 — request present.
- `in_ready` output 1 — unit can accept a request this cycle.
- `in_a` input `WIDTH` — operand A (rs1).
- `in_b` input `WIDTH` — operand B (rs2/imm).
- `control` input 5 — {funct7[0], funct7[5], funct3}.
- `out_valid` output 1 — `out` holds a result.
- `out_ready` input 1 — consumer takes the result.
- `out` output `WIDTH` — registered result.
- `busy` output 1 — state is SHIFT or MUL.

## Operation
- Encoding: 00000 ADD, 01000 SUB, 00001 SLL, 00010 SLT, 00011 SLTU, 00100 XOR, 00101 SRL, 01101 SRA, 00110 OR, 00111 AND, 10000 MUL (low `WIDTH` bits). Any other code: result 0, latency 1.
- Shift amount = `in_b[$clog2(WIDTH)-1:0]`; upper bits ignored. SRA replicates `in_a[WIDTH-1]`. SLL is a plain logical left shift.
- SLT/SLTU: result 1 or 0, zero-extended to `WIDTH`.
- Arithmetic is modulo 2^`WIDTH`; no overflow/carry output.
- FSM states: IDLE, SHIFT, MUL, DONE.
  - IDLE: `in_ready`=1. On `in_valid`: simple op, or shift with amount 0 → compute, register `out`, go DONE; shift amount ≠ 0 → latch operand and counter, go SHIFT; MUL → latch operands, clear accumulator, go MUL.
  - SHIFT: shift by min(`SHIFT_STEP`, remaining) per cycle; when remaining reaches 0, go DONE.
  - MUL: one multiplier bit per cycle (shift-add), `WIDTH` cycles, then DONE.
  - DONE: `out_valid`=1. `out_ready`=1 → the result is consumed. If `in_valid` is also high in that cycle, a request is accepted as from IDLE (back-to-back); otherwise go IDLE. `out_ready`=0 → hold `out`, `in_ready`=0.
- `in_ready` = (state==IDLE) || (state==DONE && `out_ready`); combinational from state and `out_ready`.
- Operands and `control` are sampled only on the accept cycle; later input changes are ignored.

## Timing
- Reset values: state IDLE, `out`=0, `out_valid`=0, `busy`=0, `in_ready`=1 once state is IDLE. Reset mid-operation aborts immediately and discards the in-flight result.
- Latency from accept edge to `out_valid` high: simple ops 1 cycle; shifts 1 + ceil(amt/`SHIFT_STEP`); MUL 1 + `WIDTH`.
- Throughput: one simple op per cycle while `out_ready` stays high.
- `out` and `out_valid` are stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `ALU_MC_MUL_EN` defined: MUL state and multiplier datapath are compiled in; code 10000 behaves as specified.
- Not defined: no MUL state or accumulator is built. Code 10000 falls into the "other code" case: result 0, latency 1.

## Structure
- Package `alu_mc_pkg` holds:
  - The 5-bit op-code localparams.
  - The FSM state enum.
  - A function for the shift-counter width, $clog2(`WIDTH`)+1.
- Sub-module `alu_mc_shifter`:
  - Holds the iterative shift register and counter, with start/done handshake to the parent FSM.
  - Parameterised by `WIDTH` and `SHIFT_STEP`.

## Test plan
- Reset mid-MUL (cycle 5): assert `reset` → `out_valid`=0, `out`=0, `in_ready`=1 immediately. The next ADD 2+3 returns 5 after 1 cycle.
- Simple op throughput, `out_ready` held 1: back-to-back ADD 0xFFFFFFFF+1, SUB 0−1, XOR 0xF0F0^0x0FF0 → 0x00000000, 0xFFFFFFFF, 0x0000FF00 on consecutive cycles, no bubbles.
- Shifts with `SHIFT_STEP`=1:
  - SRA 0x80000000 by 4 → 0xF8000000, `out_valid` at cycle 5.
  - SRL 0x80000000 by 31 → 0x00000001 at cycle 32.
  - Shift by 0 → unchanged operand at cycle 1.
  - Repeat with `SHIFT_STEP`=8: shift by 31 completes at cycle 5.
- Compares: SLT 0xFFFFFFFF,1 → 1; SLTU 0xFFFFFFFF,1 → 0; SLT 5,5 → 0.
- Backpressure: hold `out_ready`=0 for 10 cycles with `out_valid`=1 → `out` stable, `in_ready`=0, new `in_valid` is not accepted. Release → the pending request is accepted in the same cycle.
- MUL with `ALU_MC_MUL_EN`: 0x10000×0x10000 → 0, 7×(−3) → 0xFFFFFFEB, both at cycle 33, `busy` high cycles 1–32. Without the macro: the same request → 0 at cycle 1.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared op-codes, FSM states and sizing helper for the multi-cycle ALU.
// The MUL state exists only when ALU_MC_MUL_EN is defined.
package alu_mc_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b01000;
  localparam logic [4:0] OP_SLL  = 5'b00001;
  localparam logic [4:0] OP_SLT  = 5'b00010;
  localparam logic [4:0] OP_SLTU = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_SRA  = 5'b01101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b00111;
  localparam logic [4:0] OP_MUL  = 5'b10000;

`ifdef ALU_MC_MUL_EN
  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  typedef enum logic [1:0] {SH_LEFT, SH_RIGHT_LOG, SH_RIGHT_ARITH} sh_mode_t;

  // Counter must hold a full WIDTH-bit shift amount, hence one extra bit.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/alu_mc_shifter.sv
// Iterative shifter: loads on start, shifts min(SHIFT_STEP, remaining) per cycle.
// `last` flags the cycle whose shift finishes the job; `result` is that cycle's output.
module alu_mc_shifter
  import alu_mc_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  sh_mode_t                 mode,
  input  logic [WIDTH-1:0]         data,
  input  logic [$clog2(WIDTH)-1:0] amt,
  output logic                     last,
  output logic [WIDTH-1:0]         result
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

  sh_mode_t        mode_q;
  logic [WIDTH-1:0] val;
  logic [CW-1:0]    remaining;
  logic [CW-1:0]    step;

  assign step = (remaining < STEP) ? remaining : STEP;
  assign last = (remaining != '0) && (remaining <= STEP);

  always_comb begin
    result = val;
    case (mode_q)
      SH_LEFT:        result = val << step;
      SH_RIGHT_ARITH: result = $signed(val) >>> step;
      default:        result = val >> step;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q    <= SH_LEFT;
      val       <= '0;
      remaining <= '0;
    end else if (start) begin
      mode_q    <= mode;
      val       <= data;
      remaining <= {1'b0, amt};
    end else if (remaining != '0) begin
      val       <= result;
      remaining <= remaining - step;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready on both sides, iterative shifter
// and, when ALU_MC_MUL_EN is defined, an iterative shift-add multiplier.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [4:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam int AW = $clog2(WIDTH);

  state_t           state;
  logic             accept;
  logic             is_shift;
  logic             shift_start;
  logic [AW-1:0]    amt;
  logic [WIDTH-1:0] simple_res;
  logic [WIDTH-1:0] sh_result;
  logic             sh_last;
  sh_mode_t         sh_mode;

  assign in_ready    = (state == IDLE) || (state == DONE && out_ready);
  assign accept      = in_valid && in_ready;
  assign amt         = in_b[AW-1:0];
  assign is_shift    = (control == OP_SLL) || (control == OP_SRL) || (control == OP_SRA);
  assign shift_start = accept && is_shift && (amt != '0);

  always_comb begin
    sh_mode = SH_RIGHT_LOG;
    if (control == OP_SLL)      sh_mode = SH_LEFT;
    else if (control == OP_SRA) sh_mode = SH_RIGHT_ARITH;
  end

  // Single-cycle results; shifts only reach here with a zero amount.
  always_comb begin
    simple_res = '0;
    case (control)
      OP_ADD:  simple_res = in_a + in_b;
      OP_SUB:  simple_res = in_a - in_b;
      OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, in_a < in_b};
      OP_XOR:  simple_res = in_a ^ in_b;
      OP_OR:   simple_res = in_a | in_b;
      OP_AND:  simple_res = in_a & in_b;
      OP_SLL, OP_SRL, OP_SRA: simple_res = in_a;
      default: simple_res = '0;
    endcase
  end

  alu_mc_shifter #(
    .WIDTH      (WIDTH),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clock  (clock),
    .reset  (reset),
    .start  (shift_start),
    .mode   (sh_mode),
    .data   (in_a),
    .amt    (amt),
    .last   (sh_last),
    .result (sh_result)
  );

`ifdef ALU_MC_MUL_EN
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [AW-1:0]    mul_cnt;
  logic [WIDTH-1:0] acc_next;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef ALU_MC_MUL_EN
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      mul_cnt   <= '0;
`endif
    end else begin
      case (state)
        SHIFT: if (sh_last) begin
          out       <= sh_result;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
        end
`ifdef ALU_MC_MUL_EN
        MUL: begin
          acc     <= acc_next;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          mul_cnt <= mul_cnt + 1'b1;
          if (mul_cnt == AW'(WIDTH-1)) begin
            out       <= acc_next;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
`endif
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: ;
      endcase

      // Accept overrides the DONE->IDLE drain so back-to-back ops see no bubble.
      if (accept) begin
        if (shift_start) begin
          out_valid <= 1'b0;
          busy      <= 1'b1;
          state     <= SHIFT;
        end
`ifdef ALU_MC_MUL_EN
        else if (control == OP_MUL) begin
          out_valid <= 1'b0;
          busy      <= 1'b1;
          acc       <= '0;
          mcand     <= in_a;
          mplier    <= in_b;
          mul_cnt   <= '0;
          state     <= MUL;
        end
`endif
        else begin
          out       <= simple_res;
          out_valid <= 1'b1;
          state     <= DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: driver pushes expected results, monitor pops on out handshake.
// Expectations for code 10000 follow ALU_MC_MUL_EN.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W = 32;
`ifdef ALU_MC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid, in_valid8;
  logic         in_ready, in_ready8;
  logic         out_valid, out_valid8;
  logic         out_ready;
  logic         busy, busy8;
  logic [W-1:0] in_a, in_b, out, out8;
  logic [4:0]   control;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] exp;
    int           exp_cyc;
    string        nm;
  } item_t;
  item_t sb[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  alu_mc #(.WIDTH(W), .SHIFT_STEP(1)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .control(control), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .busy(busy)
  );

  alu_mc #(.WIDTH(W), .SHIFT_STEP(8)) u_dut8 (
    .clock(clock), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a), .in_b(in_b), .control(control), .out_valid(out_valid8),
    .out_ready(1'b1), .out(out8), .busy(busy8)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: consume one expected item per output handshake.
  always @(negedge clock) begin
    #2;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: got %h expected no result", out);
      end else begin
        item_t it;
        it = sb.pop_front();
        check(it.nm, out, it.exp);
        if (it.exp_cyc >= 0) check({it.nm, "_cyc"}, cyc, it.exp_cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [4:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] e, input int lat, input string nm, input bit push = 1'b1);
    int n;
    n = 0;
    control = c; in_a = a; in_b = b; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 300) begin
      @(negedge clock); #1; n++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL %s_accept: got in_ready 0 expected 1 within 300 cycles", nm);
    end else if (push) begin
      sb.push_back('{e, (lat >= 0) ? cyc + lat : -1, nm});
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic run8(input logic [4:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] e, input int lat, input string nm);
    int acc, n;
    control = c; in_a = a; in_b = b; in_valid8 = 1'b1;
    #1;
    check({nm, "_rdy"}, in_ready8, 1);
    acc = cyc;
    @(negedge clock);
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 50) begin
      @(negedge clock); n++;
    end
    #1;
    check({nm, "_vld"}, out_valid8, 1);
    check(nm, out8, e);
    check({nm, "_cyc"}, cyc - acc, lat);
    @(negedge clock);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock); n++;
    end
    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_valid8 = 1'b0; out_ready = 1'b1;
    control = '0; in_a = '0; in_b = '0;
    #2 reset = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Back-to-back simple ops
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, "add_wrap");
    issue(OP_SUB, 32'h0, 32'h1, 32'hFFFF_FFFF, 1, "sub_wrap");
    issue(OP_XOR, 32'hF0F0, 32'h0FF0, 32'h0000_FF00, 1, "xor");
    issue(OP_OR,  32'h00F0, 32'h0F00, 32'h0000_0FF0, 1, "or");
    issue(OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1, "and");
    issue(5'b11111, 32'h1234, 32'h5678, 32'h0, 1, "bad_op");

    // Shifts, SHIFT_STEP=1
    issue(OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 5, "sra4");
    issue(OP_SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, 32, "srl31");
    issue(OP_SLL, 32'h1234_5678, 32'h20, 32'h1234_5678, 1, "sll0");
    issue(OP_SLL, 32'h3, 32'hFFFF_FFE4, 32'h30, 5, "sll4_hi_ignored");

    // Compares
    issue(OP_SLT,  32'hFFFF_FFFF, 32'h1, 32'h1, 1, "slt_neg");
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, "sltu_big");
    issue(OP_SLT,  32'h5, 32'h5, 32'h0, 1, "slt_eq");
    drain();

    // Multiply and busy window
    begin
      issue(OP_MUL, 32'h1_0000, 32'h1_0000, 32'h0, MUL_EN ? 33 : 1, "mul_wrap");
      #1 check("busy_c1", busy, MUL_EN);
      repeat (31) @(negedge clock);
      #1 check("busy_c32", busy, MUL_EN);
      @(negedge clock);
      #1 check("busy_c33", busy, 0);
      @(negedge clock);
      issue(OP_MUL, 32'h7, 32'hFFFF_FFFD, MUL_EN ? 32'hFFFF_FFEB : 32'h0, MUL_EN ? 33 : 1, "mul_neg");
    end
    drain();

    // Backpressure: result held, new request refused until release
    out_ready = 1'b0;
    issue(OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, -1, "bp_held");
    control = OP_OR; in_a = 32'h00F0; in_b = 32'h0F00; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_out", out, 32'h0F00_0F00);
      check("bp_vld", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      @(negedge clock);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", in_ready, 1);
    sb.push_back('{32'h0000_0FF0, cyc + 1, "bp_next"});
    @(negedge clock);
    in_valid = 1'b0;
    drain();

    // Reset in the middle of a multiply
    out_ready = 1'b0;
    issue(OP_MUL, 32'h7, 32'h3, 32'h0, -1, "mul_abort", 1'b0);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out", out, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    @(negedge clock);
    reset = 1'b0;
    out_ready = 1'b1;
    issue(OP_ADD, 32'h2, 32'h3, 32'h5, 1, "add_after_rst");
    drain();

    // SHIFT_STEP=8 instance
    run8(OP_SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, 5, "s8_srl31");
    run8(OP_SRA, 32'h8000_0000, 32'd4,  32'hF800_0000, 2, "s8_sra4");
    run8(OP_SLL, 32'h1,         32'd8,  32'h0000_0100, 2, "s8_sll8");
    run8(OP_SLL, 32'hABCD,      32'd0,  32'h0000_ABCD, 1, "s8_sll0");

    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
